// File: rtl/triplet_scan_ctrl.sv
// Triplet-sum search: loads N ROM bytes, walks every i<j<k at one candidate per cycle and
// queues {a[k],a[j],a[i]} for sums equal to T (mod 256). A full FIFO stalls the scan.
module triplet_scan_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [7:0]  size_i,
  input  logic [7:0]  target_i,
  output logic        rom_cs_o,
  output logic [7:0]  rom_addr_o,
  input  logic [7:0]  rom_dout_i,
  output logic [23:0] tuple_o,
  output logic        valid_o,
  input  logic        ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  match_count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [7:0]  n_q, t_q, i_q, j_q, k_q, addr_q, mcnt_q;
  logic        rom_cs_q, busy_q, done_q;

  logic [7:0]  mem_a [256];
  logic [23:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [7:0]  sum;
  logic        hit, full, push, pop, step;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot for a push.
  always_comb begin
    sum   = mem_a[i_q] + mem_a[j_q] + mem_a[k_q];
    hit   = (state_q == S_SCAN) && (sum == t_q);
    full  = (cnt_q == FULL_CNT);
    push  = hit && !full;
    pop   = ack_i && (cnt_q != '0);
    step  = (state_q == S_SCAN) && !(hit && full);
    wr_d  = push ? wr_q + PW'(1) : wr_q;
    rd_d  = pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (state_q == S_LOAD) mem_a[addr_q] <= rom_dout_i;
    if (push) fifo_q[wr_q] <= {mem_a[k_q], mem_a[j_q], mem_a[i_q]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      t_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      addr_q   <= '0;
      mcnt_q   <= '0;
      rom_cs_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            n_q    <= size_i;
            t_q    <= target_i;
            mcnt_q <= '0;
            busy_q <= 1'b1;
            if (size_i >= 8'd3) begin
              state_q  <= S_LOAD;
              rom_cs_q <= 1'b1;
              addr_q   <= '0;
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_LOAD: begin
          if (addr_q == n_q - 8'd1) begin
            rom_cs_q <= 1'b0;
            addr_q   <= '0;
            i_q      <= 8'd0;
            j_q      <= 8'd1;
            k_q      <= 8'd2;
            state_q  <= S_SCAN;
          end else begin
            addr_q <= addr_q + 8'd1;
          end
        end
        S_SCAN: begin
          if (push && mcnt_q != 8'hFF) mcnt_q <= mcnt_q + 8'd1;
          if (step) begin
            if (k_q < n_q - 8'd1) begin
              k_q <= k_q + 8'd1;
            end else if (j_q < n_q - 8'd2) begin
              j_q <= j_q + 8'd1;
              k_q <= j_q + 8'd2;
            end else if (i_q < n_q - 8'd3) begin
              i_q <= i_q + 8'd1;
              j_q <= i_q + 8'd2;
              k_q <= i_q + 8'd3;
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_cs_o      = rom_cs_q;
  assign rom_addr_o    = addr_q;
  assign valid_o       = (cnt_q != '0);
  assign tuple_o       = valid_o ? fifo_q[rd_q] : 24'h0;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign match_count_o = mcnt_q;

endmodule

// File: tb/tb_triplet_scan_ctrl.sv
// Bench: two DUTs (FIFO depth 4 and 2) share stimulus; tuples and timing checked against a brute-force model.
module tb_triplet_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  size = '0;
  logic [7:0]  target = '0;
  logic        ack = 1'b0;
  logic [7:0]  rom [256];

  logic        cs1, cs2, v1, v2, b1, b2, d1, d2;
  logic [7:0]  ad1, ad2, mc1, mc2, dout1, dout2;
  logic [23:0] tp1, tp2;

  int n_vec = 0;
  int n_err = 0;
  int sel = 0;

  logic        s_cs, s_v, s_b, s_d;
  logic [7:0]  s_ad, s_mc;
  logic [23:0] s_tp;

  assign dout1 = rom[ad1];
  assign dout2 = rom[ad2];
  assign s_cs  = (sel != 0) ? cs2 : cs1;
  assign s_v   = (sel != 0) ? v2  : v1;
  assign s_b   = (sel != 0) ? b2  : b1;
  assign s_d   = (sel != 0) ? d2  : d1;
  assign s_ad  = (sel != 0) ? ad2 : ad1;
  assign s_mc  = (sel != 0) ? mc2 : mc1;
  assign s_tp  = (sel != 0) ? tp2 : tp1;

  always #5 clk = ~clk;

  triplet_scan_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start_i(start), .size_i(size), .target_i(target),
    .rom_cs_o(cs1), .rom_addr_o(ad1), .rom_dout_i(dout1), .tuple_o(tp1), .valid_o(v1),
    .ack_i(ack), .busy_o(b1), .done_o(d1), .match_count_o(mc1)
  );

  triplet_scan_ctrl #(.FIFO_DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .start_i(start), .size_i(size), .target_i(target),
    .rom_cs_o(cs2), .rom_addr_o(ad2), .rom_dout_i(dout2), .tuple_o(tp2), .valid_o(v2),
    .ack_i(ack), .busy_o(b2), .done_o(d2), .match_count_o(mc2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One job on the selected DUT: model enumerates i<j<k, bench pops and compares in order.
  task automatic run_job(input int s, input int n, input int t, input int holdoff,
                         input bit rnd_ack, input bit poke);
    logic [23:0] exq[$];
    logic [7:0]  sm;
    int total, cand, last_hit, cyc, got, rom_cyc, done_cyc, exp_done, depth, w;
    logic [7:0] mc_at_done;
    sel = s;
    depth = (s != 0) ? 2 : 4;
    cand = 0;
    last_hit = 0;
    for (int i = 0; i < n; i++)
      for (int j = i + 1; j < n; j++)
        for (int k = j + 1; k < n; k++) begin
          sm = rom[i] + rom[j] + rom[k];
          cand++;
          last_hit = (sm == 8'(t)) ? 1 : 0;
          if (sm == 8'(t)) exq.push_back({rom[k], rom[j], rom[i]});
        end
    total = exq.size();
    exp_done = ((n >= 3) ? n + cand : 0) + 2 + last_hit;

    @(negedge clk);
    size = 8'(n);
    target = 8'(t);
    start = 1'b1;
    ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; got = 0; rom_cyc = 0; done_cyc = 0; mc_at_done = '0;
    while (done_cyc == 0 && cyc < 20000) begin
      ack = (cyc >= holdoff) ? (rnd_ack ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      start = poke && (cyc == 2);
      if (poke && cyc == 2) begin
        size = 8'($urandom_range(3, 255));
        target = 8'($urandom);
      end
      if (s_cs) begin
        chk("rom_addr", 32'(s_ad), 32'(rom_cyc));
        rom_cyc++;
      end
      if (s_v && ack) begin
        if (exq.size() > 0) chk("tuple", 32'(s_tp), 32'(exq.pop_front()));
        got++;
      end
      if (holdoff > 0 && cyc == holdoff - 1) begin
        chk("stall_valid", 32'(s_v), 32'(1));
        chk("stall_count", 32'(s_mc), 32'((total < depth) ? total : depth));
      end
      if (s_d) begin
        done_cyc = cyc;
        mc_at_done = s_mc;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done_cyc != 0), 32'(1));
    chk("tuple_count", 32'(got), 32'(total));
    chk("match_count", 32'(mc_at_done), 32'((total > 255) ? 255 : total));
    chk("rom_cs_cycles", 32'(rom_cyc), 32'((n >= 3) ? n : 0));
    if (holdoff == 0 && !rnd_ack) chk("done_cycle", 32'(done_cyc), 32'(exp_done));
    chk("busy_after_done", 32'(s_b), 32'(0));
    chk("done_one_cycle", 32'(s_d), 32'(0));
    ack = 1'b1;
    w = 0;
    while ((b1 || b2) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("both_idle", 32'({b1, b2}), 32'(0));
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 8'h00;
    #12;
    chk("rst_valid", 32'(v1), 32'(0));
    chk("rst_busy", 32'(b1), 32'(0));
    chk("rst_done", 32'(d1), 32'(0));
    chk("rst_cs", 32'(cs1), 32'(0));
    chk("rst_addr", 32'(ad1), 32'(0));
    chk("rst_tuple", 32'(tp1), 32'(0));
    chk("rst_mcount", 32'(mc1), 32'(0));
    chk("rst_dut2", 32'({v2, b2, d2, cs2}), 32'(0));
    @(negedge clk);
    reset = 1'b1;

    rom[0] = 8'd1; rom[1] = 8'd2; rom[2] = 8'd253;
    run_job(0, 3, 0, 0, 0, 0);

    for (int a = 0; a < 4; a++) rom[a] = 8'd0;
    run_job(0, 4, 0, 0, 0, 0);
    run_job(1, 4, 0, 20, 0, 0);
    run_job(0, 4, 0, 20, 0, 0);

    rom[0] = 8'd200; rom[1] = 8'd100; rom[2] = 8'd212;
    run_job(0, 3, 0, 0, 0, 0);

    run_job(0, 2, 0, 0, 0, 0);
    run_job(1, 0, 0, 0, 0, 0);

    for (int a = 0; a < 7; a++) rom[a] = 8'($urandom_range(0, 3));
    run_job(0, 7, 4, 0, 0, 1);

    for (int a = 0; a < 13; a++) rom[a] = 8'd0;
    run_job(0, 13, 0, 0, 0, 0);

    // Reset asserted mid-SCAN with tuples stuck in the FIFO.
    sel = 0;
    @(negedge clk);
    size = 8'd8; target = 8'd0; start = 1'b1; ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset_busy", 32'(b1), 32'(1));
    chk("pre_reset_valid", 32'(v1), 32'(1));
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(v1), 32'(0));
    chk("mid_rst_busy", 32'(b1), 32'(0));
    chk("mid_rst_cs", 32'(cs1), 32'(0));
    chk("mid_rst_tuple", 32'(tp1), 32'(0));
    chk("mid_rst_mcount", 32'(mc1), 32'(0));
    chk("mid_rst_dut2", 32'({v2, b2, cs2, d2}), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    run_job(0, 8, 0, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(3, 10);
      for (int a = 0; a < n; a++) rom[a] = 8'($urandom_range(0, 3));
      run_job(r % 2, n, $urandom_range(0, 9), 0, (r >= 2), 0);
    end
    for (int a = 0; a < 12; a++) rom[a] = 8'($urandom);
    run_job(0, 12, $urandom_range(0, 255), 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/triplet_scan_ctrl.md
# triplet_scan_ctrl

Controller that sequences a zero-sum (or target-sum) triplet search over the 256x8 ROM. On `start` it loads `size` bytes from the ROM into local storage, walks every index triple i<j<k at one candidate per cycle, and queues matching tuples into a small output FIFO. The FIFO drains over a valid/ack handshake. The block sits between the ROM and the tuple consumer, and it replaces free-running loops with a cycle-bounded, back-pressured schedule.

## Interface
- `FIFO_DEPTH`, default 4: output FIFO entries; must be a power of 2, minimum 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a job when sampled high in IDLE; ignored otherwise.
- `size`  in  8  element count N, latched when `start` is accepted.
- `target`  in  8  required sum modulo 256, latched when `start` is accepted.
- `rom_cs`  out  1  ROM chip select; high only in LOAD.
- `rom_addr`  out  8  ROM address.
- `rom_dout`  in  8  ROM data; combinational, valid in the same cycle as `rom_addr`.
- `tuple`  out  24  FIFO head: `{a[k], a[j], a[i]}`, with `a[i]` in bits [7:0].
- `valid`  out  1  high when the FIFO is non-empty.
- `ack`  in  1  pops the head when `valid && ack`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in the DONE state.
- `match_count`  out  8  matches pushed in the current job; saturates at 255.

## Operation
- Reset state: IDLE. Every output resets to 0. FIFO pointers and `match_count` reset to 0.
- IDLE: on `start`, latch N and T, clear `match_count`, then:
  - go to LOAD if N≥3;
  - otherwise go directly to DRAIN.
- LOAD: drive `rom_cs=1`, `rom_addr=p`, and write `a[p] <= rom_dout`.
  - p runs from 0 to N-1, one address per cycle.
  - After p=N-1: set i=0, j=1, k=2 and go to SCAN.
- SCAN: each cycle evaluates the candidate (i,j,k).
  - Match condition: `(a[i]+a[j]+a[k]) mod 256 == T`, computed in 8-bit wrap arithmetic.
  - Match with FIFO not full: push the tuple and advance.
  - Match with FIFO full: stall. Indices hold, nothing is pushed, and the candidate is re-evaluated next cycle.
  - No match: advance.
- Index advance order:
  - if k<N-1: k++;
  - else if j<N-2: j++, k=j+1;
  - else if i<N-3: i++, j=i+1, k=i+2;
  - else this was the last candidate: go to DRAIN.
- DRAIN: wait until the FIFO is empty, then go to DONE.
- DONE: assert `done` for one cycle, then return to IDLE.
- FIFO full/empty:
  - "Full" is evaluated from the state at the start of the cycle. A pop in the same cycle does not unblock a push; the push happens on the next cycle.
  - Push and pop in the same cycle when not full: both take effect and the count is unchanged.
  - `ack` while `valid=0` is ignored.
- `match_count` increments on each push and saturates at 255. It holds its value until the next accepted `start`.
- `start` while busy is ignored; the latched N and T are unaffected.
- Reset mid-job: return to IDLE immediately. The FIFO is flushed and `valid`, `busy`, and `rom_cs` drop asynchronously.

## Timing
- `start` sampled at edge E0: `busy=1` and `rom_cs=1` from after E0; LOAD covers N cycles.
- SCAN takes C(N,3) cycles plus stall cycles. For N=4 with no stalls that is 4 cycles.
- A pushed tuple shows `valid=1` in the cycle after the push edge.
- Once in DRAIN with the FIFO empty, `done` rises one cycle later and `busy` falls one cycle after that.
- N<3: one DRAIN cycle, then DONE; `rom_cs` never asserts and `match_count=0`.
- N=0 behaves the same as N<3.
- N=255 is legal. Index widths are 8 bits and no wrap occurs because k≤254.

## Test plan
- Basic match: ROM = {1,2,253}, N=3, T=0, `ack` tied high -> exactly one `valid` cycle with `tuple=0xFD0201`; then `match_count=1`, `done` pulses, `busy=0`.
- Enumeration order: ROM = {0,0,0,0}, N=4, T=0 -> four tuples, all `0x000000`, corresponding to (0,1,2), (0,1,3), (0,2,3), (1,2,3); SCAN lasts 4 cycles; `match_count=4`.
- Back-pressure: same stimulus as enumeration with FIFO_DEPTH=2 and `ack=0` until 20 cycles after start -> SCAN stalls with `valid=1` and the FIFO full; after `ack` is raised, all 4 tuples arrive in order and none are lost or duplicated.
- Modular wrap: ROM = {200,100,212}, N=3, T=0 (200+100+212 = 512, which is 0 mod 256) -> one tuple `0xD464C8`.
- Degenerate sizes: N=2, and separately N=0 -> `rom_cs` stays 0, no `valid`, `done` pulses within 3 cycles of start.
- Reset mid-SCAN, plus `start` while busy:
  - Assert `reset` low during SCAN -> all outputs 0, FIFO empty, state IDLE; a new start runs a clean job.
  - Pulse `start` during LOAD -> the running job is unaffected.
